// File: rtl/sprite_pkg.sv
// sprite_pkg: FSM encoding, palette constants and sizing helper
// shared by the sprite blitter and its ROM.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] COL_BLACK   = 3'd0;
  localparam logic [2:0] COL_BLUE    = 3'd1;
  localparam logic [2:0] COL_GREEN   = 3'd2;
  localparam logic [2:0] COL_CYAN    = 3'd3;
  localparam logic [2:0] COL_RED     = 3'd4;
  localparam logic [2:0] COL_MAGENTA = 3'd5;
  localparam logic [2:0] COL_YELLOW  = 3'd6;
  localparam logic [2:0] COL_WHITE   = 3'd7;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: read-only sprite store,
// one registered read per clock.
module sprite_rom #(
  parameter int    DEPTH    = 1120,
  parameter int    AW       = 11,
  parameter int    DW       = 3,
  parameter string MEM_FILE = "sprite.mif"
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one sprite frame out of ROM, one clipped pixel
// per clock. Define SPRITE_TRANSP_EN to mask TRANSP_COLOUR pixels.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int    SPR_W    = 28,
  parameter int    SPR_H    = 20,
  parameter int    FRAMES   = 2,
  parameter int    COLOUR_W = 3,
  parameter int    X_W      = 9,
  parameter int    Y_W      = 8,
  parameter int    SCREEN_W = 320,
  parameter int    SCREEN_H = 240,
  parameter logic [COLOUR_W-1:0] BG_COLOUR =
    COLOUR_W'(COL_BLACK),
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR =
    COLOUR_W'(COL_BLACK),
  parameter string MEM_FILE = "sprite.mif",
  localparam int   FW       = clog2_min1(FRAMES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [FW-1:0]       frame_sel,
  input  logic                erase,
  input  logic [X_W-1:0]      x_org,
  input  logic [Y_W-1:0]      y_org,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int N_PIX = SPR_W * SPR_H;
  localparam int DEPTH = FRAMES * N_PIX;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int CW    = clog2_min1(SPR_W);
  localparam int RW    = clog2_min1(SPR_H);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

`ifdef SPRITE_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  state_t state, next;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [FW-1:0]  frame_q;
  logic           erase_q;
  logic [X_W-1:0] xo_q;
  logic [Y_W-1:0] yo_q;

  logic          last_col, last_row, issue;
  logic [AW-1:0] rom_addr;
  logic [COLOUR_W-1:0] rom_q;

  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;

  logic         p_valid;
  logic         p_in;
  logic [X_W:0] p_x;
  logic [Y_W:0] p_y;
  logic         opaque;

  assign last_col = (col == CW'(SPR_W - 1));
  assign last_row = (row == RW'(SPR_H - 1));
  assign issue    = (state == FETCH);

  assign rom_addr = AW'(32'(frame_q) * N_PIX
                  + 32'(row) * SPR_W
                  + 32'(col));

  assign x_sum = {1'b0, xo_q} + (X_W+1)'(col);
  assign y_sum = {1'b0, yo_q} + (Y_W+1)'(row);

  // erase reuses the draw mask so it clears exactly what was drawn
  assign opaque = !(TRANSP_EN && (rom_q == TRANSP_COLOUR));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = FETCH;
      FETCH:   if (last_col && last_row) next = DRAIN;
      DRAIN:   next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      frame_q <= '0;
      erase_q <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else if (state == IDLE) begin
      col <= '0;
      row <= '0;
      if (start) begin
        frame_q <= (32'(frame_sel) < FRAMES)
                 ? frame_sel : '0;
        erase_q <= erase;
        xo_q    <= x_org;
        yo_q    <= y_org;
      end
    end else if (issue) begin
      if (last_col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  sprite_rom #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .DW       (COLOUR_W),
    .MEM_FILE (MEM_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_q)
  );

  // coordinates travel alongside the ROM read
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_in    <= 1'b0;
      p_x     <= '0;
      p_y     <= '0;
    end else begin
      p_valid <= issue;
      p_in    <= (x_sum < SCR_W) && (y_sum < SCR_H);
      p_x     <= x_sum;
      p_y     <= y_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      plot <= p_valid && p_in && opaque;
      if (p_valid) begin
        x      <= p_x[X_W-1:0];
        y      <= p_y[Y_W-1:0];
        colour <= erase_q ? BG_COLOUR : rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed and randomised draws of a 4x2, 3-frame
// sprite checked against a pixel-list reference model.
module tb_sprite_blitter;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NF = 3;
  localparam int N  = W * H;
  localparam int SW = 320;
  localparam int SH = 240;
  localparam int NONE = 1000;
  localparam logic [3:0] BG  = 4'hA;
  localparam logic [3:0] KEY = 4'h0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       erase = 1'b0;
  logic [1:0] frame_sel = '0;
  logic [8:0] x_org = '0;
  logic [7:0] y_org = '0;
  logic       busy, done, plot;
  logic [8:0] x;
  logic [7:0] y;
  logic [3:0] colour;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] rom_m [NF*N];
  bit         e_plot [N];
  int         e_x [N];
  int         e_y [N];
  logic [3:0] e_col [N];

  sprite_blitter #(
    .SPR_W         (W),
    .SPR_H         (H),
    .FRAMES        (NF),
    .COLOUR_W      (4),
    .X_W           (9),
    .Y_W           (8),
    .SCREEN_W      (SW),
    .SCREEN_H      (SH),
    .BG_COLOUR     (BG),
    .TRANSP_COLOUR (KEY),
    .MEM_FILE      ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_sel (frame_sel),
    .erase     (erase),
    .x_org     (x_org),
    .y_org     (y_org),
    .busy      (busy),
    .done      (done),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .colour    (colour)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [3:0] v);
    rom_m[i] = v;
    dut.u_rom.mem[i] = v;
  endtask

  // expected pixel list straight from the sprite rules
  task automatic model(input int fs, input bit er,
                       input int xo, input int yo);
    int f;
    f = (fs < NF) ? fs : 0;
    for (int k = 0; k < N; k++) begin
      int cx;
      int cy;
      logic [3:0] pix;
      bit vis;
      cx  = xo + k % W;
      cy  = yo + k / W;
      pix = rom_m[f*N + k];
      vis = (cx < SW) && (cy < SH);
`ifdef SPRITE_TRANSP_EN
      if (pix == KEY) vis = 1'b0;
`endif
      e_plot[k] = vis;
      e_x[k]    = cx % 512;
      e_y[k]    = cy % 256;
      e_col[k]  = er ? BG : pix;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle.plot", 32'(plot), 32'(0));
      chk("idle.busy", 32'(busy), 32'(0));
      chk("idle.done", 32'(done), 32'(0));
    end
  endtask

  // entered on a negedge; start is sampled at the next posedge (E0)
  task automatic draw(input int fs, input bit er,
                      input int xo, input int yo,
                      input bit hold, input int abort_at);
    model(fs, er, xo, yo);
    frame_sel = 2'(fs);
    erase     = er;
    x_org     = 9'(xo);
    y_org     = 8'(yo);
    start     = 1'b1;
    for (int c = 0; c <= N + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start     = hold;
        frame_sel = 2'($urandom);
        erase     = ~er;
        x_org     = 9'($urandom);
        y_org     = 8'($urandom);
      end
      if (c == abort_at + 1) begin
        chk("rst.plot", 32'(plot), 32'(0));
        chk("rst.busy", 32'(busy), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.x", 32'(x), 32'(0));
        chk("rst.y", 32'(y), 32'(0));
        chk("rst.colour", 32'(colour), 32'(0));
        reset = 1'b0;
        return;
      end
      chk($sformatf("c%0d.busy", c), 32'(busy),
          32'(c >= 1 && c <= N + 2));
      chk($sformatf("c%0d.done", c), 32'(done),
          32'(c == N + 2));
      chk($sformatf("c%0d.plot", c), 32'(plot),
          32'(c >= 2 && c <= N + 1 && e_plot[(c-2) % N]));
      if (c >= 2 && c <= N + 1 && e_plot[c-2]) begin
        chk($sformatf("p%0d.x", c - 2), 32'(x),
            32'(e_x[c-2]));
        chk($sformatf("p%0d.y", c - 2), 32'(y),
            32'(e_y[c-2]));
        chk($sformatf("p%0d.colour", c - 2), 32'(colour),
            32'(e_col[c-2]));
      end
      if (c == abort_at) reset = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) load(i, 4'(i + 1));
    for (int i = N; i < NF*N; i++)
      load(i, 4'($urandom_range(1, 15)));

    repeat (2) @(negedge clk);
    chk("reset.plot", 32'(plot), 32'(0));
    chk("reset.busy", 32'(busy), 32'(0));
    chk("reset.done", 32'(done), 32'(0));
    chk("reset.x", 32'(x), 32'(0));
    chk("reset.y", 32'(y), 32'(0));
    chk("reset.colour", 32'(colour), 32'(0));
    reset = 1'b0;
    idle(2);

    draw(0, 1'b0, 10, 20, 1'b0, NONE);
    idle(2);
    draw(1, 1'b1, 10, 20, 1'b0, NONE);
    idle(1);
    draw(0, 1'b0, 318, 239, 1'b0, NONE);
    idle(1);
    draw(3, 1'b0, 100, 50, 1'b0, NONE);
    idle(1);

    load(2, 4'h0);
    load(5, 4'h0);
    draw(0, 1'b0, 10, 20, 1'b0, NONE);
    idle(1);
    draw(0, 1'b1, 10, 20, 1'b0, NONE);
    idle(1);

    draw(2, 1'b0, 40, 40, 1'b1, NONE);
    draw(0, 1'b0, 50, 60, 1'b1, NONE);
    start = 1'b0;
    idle(3);

    draw(0, 1'b0, 10, 20, 1'b0, 5);
    idle(12);
    draw(0, 1'b0, 10, 20, 1'b0, NONE);
    idle(1);

    repeat (8) begin
      for (int i = N; i < NF*N; i++)
        load(i, 4'($urandom_range(0, 15)));
      draw(int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 330)),
           int'($urandom_range(0, 245)),
           1'b0, NONE);
      idle(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
